// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiply sequencer and its ALU.
// Holds the ALU op codes, the FSM state encoding and the iteration count.
package mul_seq_ctrl_pkg;

    localparam logic [2:0] ALU_XOR = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;

    localparam int MUL_ITER = 32;
    localparam int CNT_W    = $clog2(MUL_ITER);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP_A = 3'd1,
        ST_PREP_B = 3'd2,
        ST_LOOP   = 3'd3,
        ST_FIX_LO = 3'd4,
        ST_FIX_HI = 3'd5,
        ST_DONE   = 3'd6
    } mul_state_e;

endpackage

// File: rtl/alu32.sv
// 32-bit ALU shared with the execute stage: add/sub with carry, plus bitwise ops.
// SUB computes a + ~b + cin, so cin=1 gives a true a - b.
module alu32
    import mul_seq_ctrl_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  s_i,
    input  logic        cin_i,
    output logic [31:0] y_o,
    output logic        cout_o,
    output logic        v_o
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    assign b_eff = (s_i == ALU_SUB) ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {32'd0, cin_i};

    always_comb begin
        y_o    = 32'd0;
        cout_o = 1'b0;
        v_o    = 1'b0;
        case (s_i)
            ALU_ADD, ALU_SUB: begin
                y_o    = sum[31:0];
                cout_o = sum[32];
                v_o    = (a_i[31] == b_eff[31]) && (sum[31] != a_i[31]);
            end
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_NOR: y_o = ~(a_i | b_i);
            ALU_AND: y_o = a_i & b_i;
            default: y_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle 32x32->64 MULT/MULTU sequencer: one shared ALU add per cycle,
// signed handled by negating operands up front and the product at the end.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    mul_state_e       state_q;
    logic [31:0]      mcand_q, hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sgn_q, neg_q, brw_q;
    logic             ready_q, busy_q, done_q;

    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_s;
    logic        alu_cin, alu_cout, alu_v_unused;

    logic        sgn_d;
    logic [31:0] hi_d, lo_d;

    assign sgn_d = signed_op & SIGNED_EN;

    // One LOOP step: 65-bit right shift of {carry, sum, lo}.
    assign hi_d = {alu_cout, alu_y[31:1]};
    assign lo_d = {alu_y[0], lo_q[31:1]};

    always_comb begin
        alu_a   = 32'd0;
        alu_b   = 32'd0;
        alu_s   = ALU_ADD;
        alu_cin = 1'b0;
        case (state_q)
            ST_PREP_A: begin alu_s = ALU_SUB; alu_b = mcand_q; alu_cin = 1'b1; end
            ST_PREP_B: begin alu_s = ALU_SUB; alu_b = lo_q;    alu_cin = 1'b1; end
            ST_LOOP: begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? mcand_q : 32'd0;
            end
            ST_FIX_LO: begin alu_s = ALU_SUB; alu_b = lo_q; alu_cin = 1'b1;  end
            // ~hi + borrow: carries the low-word negation into the high word
            ST_FIX_HI: begin alu_s = ALU_SUB; alu_b = hi_q; alu_cin = brw_q; end
            default: ;
        endcase
    end

    alu32 u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .s_i    (alu_s),
        .cin_i  (alu_cin),
        .y_o    (alu_y),
        .cout_o (alu_cout),
        .v_o    (alu_v_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            brw_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q <= op_a;
                        hi_q    <= 32'd0;
                        lo_q    <= op_b;
                        cnt_q   <= '0;
                        sgn_q   <= sgn_d;
                        neg_q   <= sgn_d & (op_a[31] ^ op_b[31]);
                        brw_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= sgn_d ? ST_PREP_A : ST_LOOP;
                    end
                end
                ST_PREP_A: begin
                    if (sgn_q && mcand_q[31]) mcand_q <= alu_y;
                    state_q <= ST_PREP_B;
                end
                ST_PREP_B: begin
                    if (sgn_q && lo_q[31]) lo_q <= alu_y;
                    state_q <= ST_LOOP;
                end
                ST_LOOP: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        if (sgn_q) begin
                            state_q <= ST_FIX_LO;
                        end else begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FIX_LO: begin
                    if (neg_q) begin
                        lo_q  <= alu_y;
                        brw_q <= alu_cout;
                    end
                    state_q <= ST_FIX_HI;
                end
                ST_FIX_HI: begin
                    if (neg_q) hi_q <= alu_y;
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: hand-computed products, latency,
// ignored starts and asynchronous reset mid-operation.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        ready, busy, done;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.SIGNED_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Launch one op on the next edge, scramble operands afterwards, then
    // measure done latency and busy cycles and check the product.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_p, input int exp_lat);
        int lat = 0;
        int nbusy = 0;
        @(negedge clk);
        start = 1'b1; signed_op = sgn; op_a = a; op_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = b ^ 32'h5A5A_A5A5; signed_op = ~sgn;
        if (busy) nbusy++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = k; break; end
            if (busy) nbusy++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(nbusy), 64'(exp_lat));
        chk({tag, "_prod"}, {hi, lo}, exp_p);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle"}, {61'd0, ready, busy, done}, 64'b100);
        chk({tag, "_hold"}, {hi, lo}, exp_p);
    endtask

    initial begin
        int ndone;
        #12;
        chk("rst_outs", {61'd0, ready, busy, done}, 64'b100);
        chk("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        run_op("u7x6",     1'b0, 32'd7,          32'd6,          64'h0000_0000_0000_002A, 32);
        run_op("uffxff",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32);
        run_op("u8000x2",  1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 32);
        run_op("sm3x5",    1'b1, 32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 36);
        run_op("sm4xm4",   1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC,  64'h0000_0000_0000_0010, 36);
        run_op("smnxmn",   1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 36);
        run_op("smnx1",    1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000, 36);
        run_op("s7xm1",    1'b1, 32'd7,          32'hFFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFF9, 36);

        // Starts mid-op and during DONE must be ignored.
        ndone = 0;
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; op_a = 32'd3; op_b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (k == 10) begin
                chk("ign_ready", {63'd0, ready}, 64'd0);
                start = 1'b1; op_a = 32'd9; op_b = 32'd9;
            end
            if (done) begin ndone++; break; end
        end
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("ign_idle", {61'd0, ready, busy, done}, 64'b100);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
            if (!ready) ndone += 100;
        end
        chk("ign_ndone", 64'(ndone), 64'd1);
        chk("ign_prod", {hi, lo}, 64'd9);

        // Async reset in the middle of LOOP.
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; op_a = 32'd123; op_b = 32'd456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {61'd0, ready, busy, done}, 64'b100);
        chk("arst_hilo", {hi, lo}, 64'd0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("arst_nodone", 64'(ndone), 64'd0);
        run_op("u2x8", 1'b0, 32'd2, 32'd8, 64'h10, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for 32x32 -> 64-bit multiply (MIPS MULT/MULTU) built on one shared alu32 instance.
- Uses shift-add: one ALU add per cycle. Handles signed operands by negating them before the loop and negating the product after it, with the ALU subtract op.
- Sits beside the execute stage. Results go to HI/LO registers.

Parameters:
- SIGNED_EN, 1, 1 = signed operations supported; 0 = the signed input is ignored and every operation is treated as unsigned.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- op_a  in  32  multiplicand; sampled with start
- op_b  in  32  multiplier; sampled with start
- ready  out  1  high in IDLE only
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse; hi/lo are valid and stay stable until the next accepted start
- hi  out  32  product bits [63:32]
- lo  out  32  product bits [31:0]

Behaviour:
- Reset: asynchronous on rst_n low. State becomes IDLE; hi, lo, done, busy are 0; ready is 1; the counter and internal registers are cleared. Reset mid-operation abandons the operation and produces no done.
- States: IDLE, PREP_A, PREP_B, LOOP, FIX_LO, FIX_HI, DONE.
- ALU codes: ADD = S 3'b010 with Cin 0. SUB = S 3'b011 with Cin 1, which computes a - b. ALU V is unused.
- IDLE, start=1 at edge E0:
  - latch mcand=op_a; set hi=0, lo=op_b, cnt=0.
  - neg = signed_op & SIGNED_EN & (op_a[31]^op_b[31]).
  - next state is PREP_A if signed, else LOOP.
- PREP_A: ALU computes 0 - mcand. mcand takes the result only if signed and mcand[31]=1. Next state PREP_B.
- PREP_B: ALU computes 0 - lo. lo takes the result only if signed and lo[31]=1. Next state LOOP.
- Negating 0x80000000 yields 0x80000000, which is correct as unsigned 2^31.
- LOOP, one iteration per cycle:
  - ALU computes hi + (lo[0] ? mcand : 0) with ADD.
  - {hi,lo} <= {Cout, sum, lo[31:1]}: a 65-bit right shift including the carry.
  - cnt increments; after the 32nd iteration (cnt==31), the next state is FIX_LO if signed, else DONE.
- FIX_LO: ALU computes 0 - lo with Cin=1. If neg, lo takes the result and the borrow flag takes Cout. Next state FIX_HI.
- FIX_HI: ALU S=011 with a=0, b=hi, Cin=the borrow flag. This computes ~hi + flag. If neg, hi takes the result. Next state DONE.
- DONE: done=1 for exactly one cycle, then unconditionally IDLE. Any start during DONE is ignored.
- Latency, counted from start sampled at E0: unsigned, done visible after E32; signed, done visible after E36. Latency is fixed and independent of operand values.
- start while not IDLE is ignored, and op_a/op_b changes mid-operation have no effect.
- hi/lo keep the last product through IDLE; they are overwritten at the next accepted start.
- ALU inputs are muxed per state. In IDLE/DONE the ALU inputs are driven to 0 (no toggling).

Decomposition:
- Shared package/include holds:
  - ALU op constants ALU_ADD=3'b010, ALU_SUB=3'b011, ALU_XOR=3'b000, ALU_OR=3'b100, ALU_NOR=3'b101, ALU_AND=3'b110.
  - State encodings for mul_seq_ctrl.
  - MUL_ITER=32.
- Instantiate the existing alu32 as the single datapath sub-module. There is no new sub-module; the FSM, counter and operand muxes live in mul_seq_ctrl.

Test Plan:
- Unsigned 7*6 (signed_op=0) -> done exactly after E32; hi=0x00000000, lo=0x0000002A; busy high for 32 cycles.
- Unsigned 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; exercises carry into the shift on every iteration.
- Signed 0xFFFFFFFD(-3)*5 -> done after E36; hi=0xFFFFFFFF, lo=0xFFFFFFF1. Signed -4*-4 -> hi=0, lo=0x10.
- Signed 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000. Signed 0x80000000*1 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start 3*3, then pulse start with 9*9 at cycle 10 and again during DONE -> only one done, result lo=9; ready low until IDLE.
- Assert rst_n=0 asynchronously mid-LOOP (cycle 15) -> hi/lo/done/busy=0 immediately with no done pulse; after release, 2*8 unsigned gives lo=0x10 after E32.
